// File: rtl/seg_counter_display.sv
// seg_counter_display
//   Multi-digit up/down counter with a time-multiplexed seven-segment driver
//   for an 8-digit common-anode display. A prescaler advances a DIGITS-nibble
//   counter every TICK_DIV enabled cycles. A scan divider walks the active
//   digits onto seg/AN. The low byte of the count is mirrored on LED.
//
// Build option:
//   SEG_BCD_EN  defined   -> each nibble counts decimal (max digit 9)
//               undefined -> hex counting (max digit 15)
//
// Ports:
//   CLK100MHZ  in   system clock
//   rst        in   synchronous, active-high reset
//   en         in   count enable; prescaler frozen when low
//   up_dn      in   count direction, 1 = up, 0 = down
//   load       in   synchronous load of load_val (beats a count step)
//   load_val   in   value to load, nibble k = digit k
//   seg        out  segment cathodes, active-low, seg[0]=a .. seg[6]=g
//   AN         out  digit anodes, active-low, AN[k] = digit k
//   LED        out  low byte of the count, zero-extended when DIGITS=1
module seg_counter_display #(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned SCAN_DIV = 100_000
) (
  input  logic                  CLK100MHZ,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [6:0]            seg,
  output logic [7:0]            AN,
  output logic [7:0]            LED
);

  localparam int unsigned ValW  = 4 * DIGITS;
  localparam int unsigned PreW  = $clog2(TICK_DIV);
  localparam int unsigned ScanW = $clog2(SCAN_DIV);

`ifdef SEG_BCD_EN
  localparam logic [3:0] MaxDigit = 4'd9;
`else
  localparam logic [3:0] MaxDigit = 4'd15;
`endif

  logic [ValW-1:0]  value_q, value_d, stepped;
  logic [PreW-1:0]  pre_q, pre_d;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      value_ext;
  logic [3:0]       digit;
  logic [3:0]       nib;
  logic             carry;

  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Ripple carry/borrow from nibble 0 upward; carry out of the top is dropped.
  // An up step treats any nibble >= MaxDigit as the wrap point, so a loaded
  // BCD nibble above 9 wraps to 0 on the next up step.
  always_comb begin
    stepped = value_q;
    carry   = 1'b1;
    nib     = 4'd0;
    for (int k = 0; k < int'(DIGITS); k++) begin
      nib = value_q[4*k +: 4];
      if (carry) begin
        if (up_dn) begin
          if (nib >= MaxDigit) begin
            nib = 4'd0;
          end else begin
            nib   = nib + 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (nib == 4'd0) begin
            nib = MaxDigit;
          end else begin
            nib   = nib - 4'd1;
            carry = 1'b0;
          end
        end
      end
      stepped[4*k +: 4] = nib;
    end
  end

  // Count path: load beats a pending step; en=0 freezes the prescaler.
  always_comb begin
    value_d = value_q;
    pre_d   = pre_q;
    if (load) begin
      value_d = load_val;
      pre_d   = '0;
    end else if (en) begin
      if (pre_q == PreW'(TICK_DIV - 1)) begin
        pre_d   = '0;
        value_d = stepped;
      end else begin
        pre_d = pre_q + PreW'(1);
      end
    end
  end

  // Scan path runs independently of en and load.
  always_comb begin
    scan_d = scan_q + ScanW'(1);
    idx_d  = idx_q;
    if (scan_q == ScanW'(SCAN_DIV - 1)) begin
      scan_d = '0;
      idx_d  = (idx_q == 3'(DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
    end
  end

  assign value_ext = 32'(value_q);
  assign digit     = value_ext[{idx_q, 2'b00} +: 4];

  always_ff @(posedge CLK100MHZ) begin
    if (rst) begin
      value_q <= '0;
      pre_q   <= '0;
      scan_q  <= '0;
      idx_q   <= 3'd0;
      seg     <= 7'b1000000;
      AN      <= 8'b11111110;
      LED     <= 8'h00;
    end else begin
      value_q <= value_d;
      pre_q   <= pre_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      // Outputs reflect value/idx as of the previous edge.
      seg     <= decode(digit);
      AN      <= ~(8'd1 << idx_q);
      LED     <= value_ext[7:0];
    end
  end

endmodule

// File: tb/tb_seg_counter_display.sv
// Testbench for seg_counter_display with DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
// A cycle-level reference model (integer count, enabled-cycle counter and
// a free-running scan cycle count) predicts seg/AN/LED after every edge.
module tb_seg_counter_display;

  localparam int unsigned DIGITS   = 2;
  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned SCAN_DIV = 2;

`ifdef SEG_BCD_EN
  localparam int MaxD = 9;
`else
  localparam int MaxD = 15;
`endif

  logic       CLK100MHZ = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       up_dn = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;
  logic [6:0] seg;
  logic [7:0] AN;
  logic [7:0] LED;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state
  int m_val  = 0;  // counter value as an integer
  int m_pre  = 0;  // enabled cycles since last step/load
  int m_scan = 0;  // cycles since reset, modulo one full scan
  logic [6:0] e_seg;
  logic [7:0] e_an, e_led;
  logic [6:0] glyph [16];

  seg_counter_display #(
    .DIGITS  (DIGITS),
    .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .CLK100MHZ(CLK100MHZ),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .seg      (seg),
    .AN       (AN),
    .LED      (LED)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Per-digit step using digit arrays and plain arithmetic.
  function automatic int next_val(input int v, input logic up);
    int d[DIGITS];
    int r;
    for (int k = 0; k < int'(DIGITS); k++) d[k] = (v >> (4 * k)) & 15;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (up) begin
        if (d[k] >= MaxD) d[k] = 0;
        else begin d[k] = d[k] + 1; break; end
      end else begin
        if (d[k] == 0) d[k] = MaxD;
        else begin d[k] = d[k] - 1; break; end
      end
    end
    r = 0;
    for (int k = 0; k < int'(DIGITS); k++) r = r | (d[k] << (4 * k));
    return r;
  endfunction

  // Predict one edge, wait for it, then compare all outputs.
  task automatic cycle();
    int idx;
    if (rst) begin
      e_an = 8'hFE; e_seg = 7'b1000000; e_led = 8'h00;
      m_val = 0; m_pre = 0; m_scan = 0;
    end else begin
      idx   = m_scan / SCAN_DIV;
      e_an  = 8'hFF & ~(8'd1 << idx);
      e_seg = glyph[(m_val >> (4 * idx)) & 15];
      e_led = 8'(m_val & 255);
      if (load) begin
        m_val = int'(load_val); m_pre = 0;
      end else if (en) begin
        m_pre++;
        if (m_pre == TICK_DIV) begin
          m_pre = 0;
          m_val = next_val(m_val, up_dn);
        end
      end
      m_scan = (m_scan + 1) % (SCAN_DIV * DIGITS);
    end
    @(posedge CLK100MHZ);
    #1;
    check("seg", 32'(seg), 32'(e_seg));
    check("AN", 32'(AN), 32'(e_an));
    check("LED", 32'(LED), 32'(e_led));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_val = v;
    cycle();
    load = 1'b0;
  endtask

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Reset, then idle scan with en=0
    rst = 1'b1; run(2);
    rst = 1'b0; en = 1'b0;
    check("rst_an", 32'(AN), 32'h FE);
    check("rst_seg", 32'(seg), 32'h40);
    check("rst_led", 32'(LED), 32'h00);
    run(8);
    check("idle_led", 32'(LED), 32'h00);

    // Hex/BCD up wrap from FE
    en = 1'b1; up_dn = 1'b1;
    do_load(8'hFE);
    run(1); check("up_fe", 32'(LED), 32'hFE);
`ifndef SEG_BCD_EN
    run(4); check("up_ff", 32'(LED), 32'hFF);
    run(4); check("up_00", 32'(LED), 32'h00);
    run(4); check("up_01", 32'(LED), 32'h01);
`else
    run(12);
`endif

    // Down borrow
    up_dn = 1'b0;
    do_load(8'h10);
    run(1); check("dn_10", 32'(LED), 32'h10);
`ifdef SEG_BCD_EN
    run(4); check("dn_09", 32'(LED), 32'h09);
    run(4); check("dn_08", 32'(LED), 32'h08);
`else
    run(4); check("dn_0f", 32'(LED), 32'h0F);
    run(4); check("dn_0e", 32'(LED), 32'h0E);
`endif
    do_load(8'h00);
    run(5);
`ifdef SEG_BCD_EN
    check("dn_wrap", 32'(LED), 32'h99);
`else
    check("dn_wrap", 32'(LED), 32'hFF);
`endif

`ifdef SEG_BCD_EN
    up_dn = 1'b1;
    do_load(8'h19); run(5); check("bcd_19", 32'(LED), 32'h20);
    do_load(8'h99); run(5); check("bcd_99", 32'(LED), 32'h00);
    do_load(8'h0C); run(5); check("bcd_0c", 32'(LED), 32'h10);
`endif

    // Load colliding with a pending step
    up_dn = 1'b1;
    do_load(8'h30);
    run(3);
    do_load(8'h55);
    run(1); check("coll_55a", 32'(LED), 32'h55);
    run(3); check("coll_55b", 32'(LED), 32'h55);
    run(1); check("coll_56", 32'(LED), 32'h56);

    // Enable gating at pre=2
    do_load(8'h40);
    run(2);
    en = 1'b0; run(10); check("gate_hold", 32'(LED), 32'h40);
    en = 1'b1; run(2); check("gate_pre", 32'(LED), 32'h40);
    run(1); check("gate_step", 32'(LED), 32'h41);

    // Mid-scan reset
    run(1);
    rst = 1'b1; run(1);
    check("mid_rst_an", 32'(AN), 32'hFE);
    check("mid_rst_seg", 32'(seg), 32'h40);
    check("mid_rst_led", 32'(LED), 32'h00);
    rst = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst      = ($urandom_range(0, 99) == 0);
      load     = ($urandom_range(0, 19) == 0);
      load_val = 8'($urandom_range(0, 255));
      en       = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 9) == 0) up_dn = ~up_dn;
      cycle();
    end
    rst = 1'b0; load = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/seg_counter_display.md
# seg_counter_display

Parametrised multi-digit up/down counter with a time-multiplexed seven-segment driver for the board's 8-digit common-anode display. A prescaler advances a DIGITS-nibble counter at a fixed tick rate. A second divider scans the digits onto `seg`/`AN`, and the low byte of the count is mirrored on `LED`. It sits directly behind the board pins and replaces the single-digit free-running segment counter in the display demos.

## Interface
Parameters:
- `DIGITS`, 4: number of active digits and counter nibbles, 1..8.
- `TICK_DIV`, 25_000_000: clock cycles per count step, ≥2.
- `SCAN_DIV`, 100_000: clock cycles per digit scan slot, ≥2.

Ports:
- `CLK100MHZ`  in  1  system clock, 100 MHz.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  count enable; prescaler frozen when low.
- `up_dn`  in  1  count direction; 1 = up, 0 = down.
- `load`  in  1  synchronous load of `load_val`.
- `load_val`  in  4*DIGITS  value to load, nibble k = digit k.
- `seg`  out  7  segment cathodes, active-low, `seg[0]`=a … `seg[6]`=g.
- `AN`  out  8  digit anodes, active-low, `AN[k]` = digit k.
- `LED`  out  8  `value[7:0]`, zero-extended when DIGITS=1.

## Operation
- State:
  - `value` [4*DIGITS-1:0]
  - `pre` prescaler, 0..TICK_DIV-1
  - `scan` divider, 0..SCAN_DIV-1
  - `idx` digit index, 0..DIGITS-1
  - registered `seg`, `AN`, `LED`
- Priority per edge: `rst` > `load` > count step.
- Load: `value <= load_val`, `pre <= 0`. Scan is unaffected.
- Count step: occurs when `en`=1 and `pre`==TICK_DIV-1. `pre` wraps to 0 and `value` steps by one in direction `up_dn`. Otherwise, if `en`=1, `pre` increments. If `en`=0, `pre` holds.
- Nibble arithmetic, ripple carry/borrow from nibble 0 upward. Digit max M = 15 (hex) or 9 (BCD, see Configuration).
  - Up: a nibble ≥M becomes 0 with carry out.
  - Down: a nibble of 0 becomes M with borrow out.
  - All-max +1 → all zero. All-zero −1 → all M.
  - Carry/borrow out of the top nibble is discarded.
- Scan runs regardless of `en`/`load`. When `scan`==SCAN_DIV-1, `scan` wraps to 0 and `idx` advances, wrapping DIGITS-1 → 0.
- Outputs:
  - `AN` has exactly bit `idx` low; bits ≥DIGITS are always 1.
  - `seg` is the decode of nibble `idx` of `value`.
- Decode (a..g lit for 0–F, standard hex glyphs):
  - 0 = 7'b1000000, 1 = 7'b1111001, 8 = 7'b0000000.
  - A = 7'b0001000, F = 7'b0001110.

## Timing
- Reset values:
  - `value`=0, `pre`=0, `scan`=0, `idx`=0
  - `AN`=8'b11111110, `seg`=7'b1000000, `LED`=8'h00
- Output latency: `seg`/`AN`/`LED` are registered. They reflect `value` and `idx` as of the previous edge, so there is 1-cycle latency after a step, load or scan advance.
- Step period: exactly TICK_DIV cycles of `en`=1. Cycles with `en`=0 do not count toward the period.
- `load` on the same edge as a pending step: the load wins and the step is lost.
- `up_dn` is sampled only on the step edge. A direction change mid-period needs no restart.
- `rst` asserted mid-period or mid-scan: all state returns to reset values on that edge.

## Configuration
- `SEG_BCD_EN`:
  - Defined: each nibble counts decimal, M=9. Loaded nibbles >9 wrap to 0 with carry on the next up step, and decrement normally on down steps.
  - Undefined: hex counting, M=15.
- Decode and scan are identical in both builds.

## Test plan
Parameters for all scenarios: DIGITS=2, TICK_DIV=4, SCAN_DIV=2.
- Reset: assert `rst` 2 cycles, then release with `en`=0 → `AN`=8'hFE, `seg`=7'b1000000, `LED`=0. `AN` alternates FE/FD every 2 cycles and `value` stays 0.
- Hex up wrap: load 8'hFE, `en`=1, `up_dn`=1 → `LED` FE→FF→00→01, one step every 4 cycles.
- Down borrow: load 8'h10, `up_dn`=0 → 10→0F→0E. Load 8'h00 and step down → FF (hex build) or 99 (SEG_BCD_EN build).
- BCD carry (SEG_BCD_EN): load 8'h19, step up → 20. Load 8'h99, step up → 00. Load 8'h0C, step up → 10.
- Load vs step collision: assert `load`=1 with `load_val`=8'h55 on the edge where `pre`==3 → `value`=55, no step. The next step occurs 4 enabled cycles later.
- Enable gating and mid-operation reset: hold `en`=0 for 10 cycles at `pre`=2 → no step, scan continues. Re-enable → step after exactly 2 cycles. Assert `rst` mid-scan → outputs return to reset values on the next edge.
